// File: rtl/set_member_scan_if.sv
// Handshake and configuration bundle for set_member_scan: config writes,
// query (q_*) and result (r_*) channels.
interface set_member_scan_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
);
    localparam int IW = $clog2(DEPTH);

    logic             cfg_we;
    logic [IW-1:0]    cfg_idx;
    logic [WIDTH-1:0] cfg_val;
    logic             cfg_clr;
    logic             q_valid;
    logic             q_ready;
    logic [WIDTH-1:0] q_data;
    logic             r_valid;
    logic             r_ready;
    logic             r_hit;
    logic [IW-1:0]    r_idx;

    modport master (
        output cfg_we, cfg_idx, cfg_val, cfg_clr, q_valid, q_data, r_ready,
        input  q_ready, r_valid, r_hit, r_idx
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_val, cfg_clr, q_valid, q_data, r_ready,
        output q_ready, r_valid, r_hit, r_idx
    );
endinterface

// File: rtl/set_member_scan.sv
// Sequential set-membership engine: one comparator walks a programmable
// DEPTH-entry set, one entry per cycle, and reports the lowest matching index.
module set_member_scan #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 8
) (
    input logic            clk,
    input logic            rst_n,
    set_member_scan_if.slave bus
);
    localparam int IW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] vals [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [WIDTH-1:0] query;
    logic [IW-1:0]    ptr;
    logic             accept;
    logic             match;
    logic             last;

    assign accept = bus.q_valid && (state == IDLE);
    // Comparison uses registered set contents, so same-cycle config writes are not seen.
    assign match  = valid[ptr] && (vals[ptr] == query);
    assign last   = (ptr == IW'(DEPTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.q_valid) state_nxt = SCAN;
            SCAN:    if (match || last) state_nxt = RESP;
            RESP:    if (bus.r_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.q_ready = (state == IDLE);
        bus.r_valid = (state == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            bus.r_hit <= 1'b0;
            bus.r_idx <= '0;
        end else if (accept) begin
            ptr <= '0;
        end else if (state == SCAN) begin
            if (match) begin
                bus.r_hit <= 1'b1;
                bus.r_idx <= ptr;
            end else if (last) begin
                bus.r_hit <= 1'b0;
                bus.r_idx <= '0;
            end else begin
                ptr <= ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            query <= bus.q_data;
        end
    end

    // Stored values are never reset; only the valid bits gate matching.
    always_ff @(posedge clk) begin
        if (bus.cfg_we) begin
            vals[bus.cfg_idx] <= bus.cfg_val;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (bus.cfg_clr) begin
            valid <= '0;
        end else if (bus.cfg_we) begin
            valid[bus.cfg_idx] <= 1'b1;
        end
    end
endmodule

// File: tb/tb_set_member_scan.sv
// Directed bench for set_member_scan: programs sets, issues queries and
// compares hit/index/latency against hand-computed values.
module tb_set_member_scan;
    localparam int WIDTH = 4;
    localparam int DEPTH = 8;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   lat;
    int   seen;

    set_member_scan_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    set_member_scan #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input int idx, input int val);
        bus.cfg_we  = 1'b1;
        bus.cfg_idx = 3'(idx);
        bus.cfg_val = 4'(val);
        step();
        bus.cfg_we  = 1'b0;
    endtask

    task automatic cfg_clear();
        bus.cfg_clr = 1'b1;
        step();
        bus.cfg_clr = 1'b0;
    endtask

    // Drives the query through its accept edge; lat counts cycles from the accept cycle.
    task automatic start_query(input string tag, input int data);
        bus.q_valid = 1'b1;
        bus.q_data  = 4'(data);
        check_eq({tag, "_qready"}, 32'(bus.q_ready), 32'd1);
        step();
        bus.q_valid = 1'b0;
        lat = 1;
    endtask

    task automatic finish_query(input string tag, input int hit, input int idx,
                                input int exp_lat, input int hold);
        while (!bus.r_valid && lat < 40) begin
            step();
            lat++;
        end
        check_eq({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check_eq({tag, "_hit"}, 32'(bus.r_hit), 32'(hit));
        check_eq({tag, "_idx"}, 32'(bus.r_idx), 32'(idx));
        check_eq({tag, "_qready_resp"}, 32'(bus.q_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            step();
            check_eq({tag, "_hold_rvalid"}, 32'(bus.r_valid), 32'd1);
            check_eq({tag, "_hold_hit"}, 32'(bus.r_hit), 32'(hit));
            check_eq({tag, "_hold_idx"}, 32'(bus.r_idx), 32'(idx));
            check_eq({tag, "_hold_qready"}, 32'(bus.q_ready), 32'd0);
        end
        bus.r_ready = 1'b1;
        step();
        bus.r_ready = 1'b0;
        check_eq({tag, "_done_rvalid"}, 32'(bus.r_valid), 32'd0);
        check_eq({tag, "_done_qready"}, 32'(bus.q_ready), 32'd1);
    endtask

    task automatic run_query(input string tag, input int data, input int hit,
                             input int idx, input int exp_lat);
        start_query(tag, data);
        finish_query(tag, hit, idx, exp_lat, 0);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        lat         = 0;
        seen        = 0;
        rst_n       = 1'b0;
        bus.cfg_we  = 1'b0;
        bus.cfg_idx = '0;
        bus.cfg_val = '0;
        bus.cfg_clr = 1'b0;
        bus.q_valid = 1'b0;
        bus.q_data  = '0;
        bus.r_ready = 1'b0;
        repeat (2) step();
        check_eq("rst_rvalid", 32'(bus.r_valid), 32'd0);
        check_eq("rst_qready", 32'(bus.q_ready), 32'd1);
        check_eq("rst_hit", 32'(bus.r_hit), 32'd0);
        check_eq("rst_idx", 32'(bus.r_idx), 32'd0);
        rst_n = 1'b1;
        step();

        // Basic set {2,3,4,5} in entries 0..3
        cfg_write(0, 2);
        cfg_write(1, 3);
        cfg_write(2, 4);
        cfg_write(3, 5);
        run_query("q4", 4, 1, 2, 4);
        run_query("q9", 9, 0, 0, 9);
        run_query("q2", 2, 1, 0, 2);

        // Duplicates: lowest valid index wins, then invalidated entries drop out
        cfg_write(1, 7);
        cfg_write(6, 7);
        run_query("dup_a", 7, 1, 1, 3);
        cfg_write(1, 0);
        run_query("dup_b", 7, 1, 6, 8);
        cfg_clear();
        run_query("dup_clr", 7, 0, 0, 9);

        // Result held while consumer stalls
        cfg_write(0, 2);
        start_query("hold", 2);
        finish_query("hold", 1, 0, 2, 5);

        // Clear beats write in the same cycle
        bus.cfg_clr = 1'b1;
        bus.cfg_we  = 1'b1;
        bus.cfg_idx = 3'd3;
        bus.cfg_val = 4'd5;
        step();
        bus.cfg_clr = 1'b0;
        bus.cfg_we  = 1'b0;
        run_query("clr_we", 5, 0, 0, 9);

        // Write to the entry under comparison is not seen by that comparison
        cfg_write(4, 9);
        start_query("midw", 6);
        repeat (4) begin
            step();
            lat++;
        end
        bus.cfg_we  = 1'b1;
        bus.cfg_idx = 3'd4;
        bus.cfg_val = 4'd6;
        step();
        lat++;
        bus.cfg_we  = 1'b0;
        finish_query("midw", 0, 0, 9, 0);
        run_query("midw_after", 6, 1, 4, 6);

        // Asynchronous reset mid-scan drops the query
        cfg_write(7, 3);
        start_query("arst", 3);
        repeat (3) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_rvalid", 32'(bus.r_valid), 32'd0);
        check_eq("arst_qready", 32'(bus.q_ready), 32'd1);
        check_eq("arst_hit", 32'(bus.r_hit), 32'd0);
        check_eq("arst_idx", 32'(bus.r_idx), 32'd0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (bus.r_valid) seen++;
        end
        check_eq("arst_no_result", 32'(seen), 32'd0);
        run_query("arst_requery", 3, 0, 0, 9);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
